// File: rtl/ks_add_scheduler.sv
// Round-robin two-requester front end for one shared 32-bit adder.
// Each operation is NWORDS words, added LSW first with the carry chained through a register.
module ks_add_scheduler #(
  parameter  int NWORDS = 2,
  localparam int OW     = 32 * NWORDS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  input  logic          req1_valid,
  output logic          req0_ready,
  output logic          req1_ready,
  input  logic [OW-1:0] req0_a,
  input  logic [OW-1:0] req0_b,
  input  logic [OW-1:0] req1_a,
  input  logic [OW-1:0] req1_b,
  input  logic          req0_cin,
  input  logic          req1_cin,
  output logic          rsp0_valid,
  output logic          rsp1_valid,
  input  logic          rsp0_ready,
  input  logic          rsp1_ready,
  output logic [OW-1:0] rsp_sum,
  output logic          rsp_cout,
  output logic [31:0]   add_a,
  output logic [31:0]   add_b,
  output logic          add_cin,
  input  logic [31:0]   add_sum,
  input  logic          add_cout,
  output logic          busy,
  output logic          owner
);

  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_rr, r_owner, r_carry, r_cout;
  logic [IW-1:0]   r_widx;
  logic [OW-1:0]   r_a, r_b, r_sum;

  logic            w_any, w_gidx, w_grant, w_last, w_rsp_hs;
  logic [1:0][OW-1:0] w_req_a, w_req_b;
  logic [1:0]      w_req_cin;

  assign w_req_a   = {req1_a, req0_a};
  assign w_req_b   = {req1_b, req0_b};
  assign w_req_cin = {req1_cin, req0_cin};

  // Arbitration: a lone requester always wins; a tie goes to the rr pointer.
  assign w_any   = req0_valid | req1_valid;
  assign w_gidx  = (req0_valid && req1_valid) ? r_rr : req1_valid;
  assign w_grant = (r_state == IDLE) && w_any;
  assign w_last  = (r_widx == IW'(NWORDS - 1));

  assign req0_ready = w_grant && !w_gidx;
  assign req1_ready = w_grant &&  w_gidx;
  assign rsp0_valid = (r_state == RESP) && !r_owner;
  assign rsp1_valid = (r_state == RESP) &&  r_owner;
  assign w_rsp_hs   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

  assign rsp_sum  = r_sum;
  assign rsp_cout = r_cout;
  assign busy     = (r_state != IDLE);
  assign owner    = r_owner;

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (r_state == RUN) begin
      add_a   = r_a[32*int'(r_widx) +: 32];
      add_b   = r_b[32*int'(r_widx) +: 32];
      add_cin = r_carry;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any)    w_state_nxt = RUN;
      RUN:     if (w_last)   w_state_nxt = RESP;
      RESP:    if (w_rsp_hs) w_state_nxt = IDLE;
      default:               w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rr    <= 1'b0;
      r_owner <= 1'b0;
      r_widx  <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_a     <= w_req_a[w_gidx];
        r_b     <= w_req_b[w_gidx];
        r_carry <= w_req_cin[w_gidx];
        r_widx  <= '0;
        r_owner <= w_gidx;
        r_rr    <= ~w_gidx;
      end else if (r_state == RUN) begin
        r_sum[32*int'(r_widx) +: 32] <= add_sum;
        r_carry <= add_cout;
        r_widx  <= r_widx + IW'(1);
        if (w_last) r_cout <= add_cout;
      end
    end
  end

endmodule
